// File: rtl/imuldiv_div_requester.sv
// ---------------------------------------------------------------------------
// imuldiv_div_requester
//   Client-side initiator for the iterative divider. It accepts tagged divide
//   commands from the pipeline and issues them to the divider in order. It
//   keeps the tags of in-flight commands in a FIFO and joins each divider
//   response with its tag. The joined {tag, quotient, remainder, divzero}
//   result goes back to the pipeline through a one-entry buffer.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   cmd_val/cmd_rdy/cmd_msg_*  pipeline command (fn, a, b, tag)
//   divreq_val/rdy/msg_*       request to divider, driven from registers
//   divresp_val/rdy/msg_result divider response {rem[63:32], quot[31:0]}
//   rsp_val/rdy/msg_*          response to pipeline, driven from registers
//   outstanding                commands accepted but not yet returned
//   proto_err                  sticky: divider response with nothing pending
// ---------------------------------------------------------------------------
module imuldiv_div_requester #(
  parameter int TAG_W   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_val,
  output logic                       cmd_rdy,
  input  logic                       cmd_msg_fn,
  input  logic [31:0]                cmd_msg_a,
  input  logic [31:0]                cmd_msg_b,
  input  logic [TAG_W-1:0]           cmd_msg_tag,
  output logic                       divreq_val,
  input  logic                       divreq_rdy,
  output logic                       divreq_msg_fn,
  output logic [31:0]                divreq_msg_a,
  output logic [31:0]                divreq_msg_b,
  input  logic                       divresp_val,
  output logic                       divresp_rdy,
  input  logic [63:0]                divresp_msg_result,
  output logic                       rsp_val,
  input  logic                       rsp_rdy,
  output logic [31:0]                rsp_msg_quot,
  output logic [31:0]                rsp_msg_rem,
  output logic [TAG_W-1:0]           rsp_msg_tag,
  output logic                       rsp_msg_divzero,
  output logic [$clog2(MAX_OUT):0]   outstanding,
  output logic                       proto_err
);

  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + 1;

  // Request buffer
  logic              reqbuf_val_r;
  logic              reqbuf_fn_r;
  logic [31:0]       reqbuf_a_r;
  logic [31:0]       reqbuf_b_r;

  // Tag FIFO: each entry is {tag, divzero}
  logic [ENT_W-1:0]  fifo_mem_r [MAX_OUT];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;

  // Response buffer
  logic              rspbuf_val_r;
  logic [31:0]       rspbuf_quot_r;
  logic [31:0]       rspbuf_rem_r;
  logic [TAG_W-1:0]  rspbuf_tag_r;
  logic              rspbuf_dz_r;

  logic              proto_err_r;

  logic              cmd_rdy_s;
  logic              cmd_fire_s;
  logic              divreq_fire_s;
  logic              divresp_fire_s;
  logic              rsp_fire_s;
  logic              unmatched_s;
  logic [ENT_W-1:0]  head_s;

  // Handshake decode. cmd_rdy is forced low while reset is asserted.
  assign cmd_rdy_s      = reset & ~reqbuf_val_r & (count_r < CNT_W'(MAX_OUT));
  assign cmd_fire_s     = cmd_val & cmd_rdy_s;
  assign divreq_fire_s  = reqbuf_val_r & divreq_rdy;
  assign divresp_fire_s = divresp_val & ~rspbuf_val_r;
  assign rsp_fire_s     = rspbuf_val_r & rsp_rdy;
  assign head_s         = fifo_mem_r[rd_ptr_r];

  // A divider response is unmatched when every FIFO entry already has its
  // result sitting in the response buffer (or the FIFO is empty).
  assign unmatched_s    = (count_r == {{PTR_W{1'b0}}, rspbuf_val_r});

  // Occupancy next-state: a push and a pop on the same edge cancel out.
  always_comb begin
    count_nxt_s = count_r;
    case ({cmd_fire_s, rsp_fire_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Request buffer: load on command accept, release on divider accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reqbuf_val_r <= 1'b0;
      reqbuf_fn_r  <= 1'b0;
      reqbuf_a_r   <= 32'd0;
      reqbuf_b_r   <= 32'd0;
    end else if (cmd_fire_s) begin
      reqbuf_val_r <= 1'b1;
      reqbuf_fn_r  <= cmd_msg_fn;
      reqbuf_a_r   <= cmd_msg_a;
      reqbuf_b_r   <= cmd_msg_b;
    end else if (divreq_fire_s) begin
      reqbuf_val_r <= 1'b0;
    end
  end

  // Tag FIFO: push on command accept, pop only when the pipeline takes the
  // response, so the head stays valid while the response is buffered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_OUT; i++) begin
        fifo_mem_r[i] <= {ENT_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (cmd_fire_s) begin
        fifo_mem_r[wr_ptr_r] <= {cmd_msg_tag, (cmd_msg_b == 32'd0)};
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (rsp_fire_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  // Response buffer: join divider result with the FIFO head tag. A result
  // with no matching entry is accepted and dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rspbuf_val_r  <= 1'b0;
      rspbuf_quot_r <= 32'd0;
      rspbuf_rem_r  <= 32'd0;
      rspbuf_tag_r  <= {TAG_W{1'b0}};
      rspbuf_dz_r   <= 1'b0;
    end else if (divresp_fire_s && !unmatched_s) begin
      rspbuf_val_r  <= 1'b1;
      rspbuf_quot_r <= divresp_msg_result[31:0];
      rspbuf_rem_r  <= divresp_msg_result[63:32];
      rspbuf_tag_r  <= head_s[ENT_W-1:1];
      rspbuf_dz_r   <= head_s[0];
    end else if (rsp_fire_s) begin
      rspbuf_val_r  <= 1'b0;
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      proto_err_r <= 1'b0;
    end else if (divresp_val && unmatched_s) begin
      proto_err_r <= 1'b1;
    end
  end

  assign cmd_rdy         = cmd_rdy_s;
  assign divreq_val      = reqbuf_val_r;
  assign divreq_msg_fn   = reqbuf_fn_r;
  assign divreq_msg_a    = reqbuf_a_r;
  assign divreq_msg_b    = reqbuf_b_r;
  assign divresp_rdy     = ~rspbuf_val_r;
  assign rsp_val         = rspbuf_val_r;
  assign rsp_msg_quot    = rspbuf_quot_r;
  assign rsp_msg_rem     = rspbuf_rem_r;
  assign rsp_msg_tag     = rspbuf_tag_r;
  assign rsp_msg_divzero = rspbuf_dz_r;
  assign outstanding     = count_r;
  assign proto_err       = proto_err_r;

endmodule

// File: tb/tb_imuldiv_div_requester.sv
// ---------------------------------------------------------------------------
// tb_imuldiv_div_requester
//   Bench for imuldiv_div_requester. The bench also acts as the divider
//   (a queue of results computed with plain arithmetic). It keeps an in-order
//   queue of expected responses and checks every DUT output once per cycle.
// ---------------------------------------------------------------------------
module tb_imuldiv_div_requester;

  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_val, cmd_rdy, cmd_msg_fn;
  logic [31:0] cmd_msg_a, cmd_msg_b;
  logic [3:0]  cmd_msg_tag;
  logic        divreq_val, divreq_rdy, divreq_msg_fn;
  logic [31:0] divreq_msg_a, divreq_msg_b;
  logic        divresp_val, divresp_rdy;
  logic [63:0] divresp_msg_result;
  logic        rsp_val, rsp_rdy;
  logic [31:0] rsp_msg_quot, rsp_msg_rem;
  logic [3:0]  rsp_msg_tag;
  logic        rsp_msg_divzero;
  logic [2:0]  outstanding;
  logic        proto_err;

  imuldiv_div_requester #(.TAG_W(TAG_W), .MAX_OUT(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_msg_fn(cmd_msg_fn),
    .cmd_msg_a(cmd_msg_a), .cmd_msg_b(cmd_msg_b), .cmd_msg_tag(cmd_msg_tag),
    .divreq_val(divreq_val), .divreq_rdy(divreq_rdy), .divreq_msg_fn(divreq_msg_fn),
    .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
    .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
    .divresp_msg_result(divresp_msg_result),
    .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_msg_quot(rsp_msg_quot),
    .rsp_msg_rem(rsp_msg_rem), .rsp_msg_tag(rsp_msg_tag),
    .rsp_msg_divzero(rsp_msg_divzero), .outstanding(outstanding),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  tag;
    logic        dz;
    logic [31:0] q;
    logic [31:0] r;
  } rsp_t;

  int total = 0;
  int bad   = 0;

  // Model state
  rsp_t        exp_q[$];    // accepted, not yet returned, in command order
  rsp_t        ret_log[$];  // responses observed at the DUT output
  logic [63:0] div_q[$];    // divider results waiting to be returned
  logic        m_req_pend = 1'b0;
  logic        m_req_fn;
  logic [31:0] m_req_a, m_req_b;
  logic        m_rsp_val = 1'b0;
  logic        m_perr = 1'b0;
  logic        stub_en = 1'b1;
  logic        inject = 1'b0;
  logic        last_cf = 1'b0;
  int          n_qfire = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference divider: {rem, quot}; divide-by-zero gives all-ones / dividend.
  function automatic logic [63:0] divide(input logic fn, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (fn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else if (fn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // One cycle: called at negedge+1 with inputs set; checks, advances model.
  task automatic tick();
    logic exp_cmd_rdy, cf, rf, qf, sf, unm;
    rsp_t e, o;
    logic [63:0] res;
    if (inject) begin
      divresp_val = 1'b1;
      divresp_msg_result = 64'h0000_0001_0000_1234;
    end else if (stub_en && div_q.size() != 0) begin
      divresp_val = 1'b1;
      divresp_msg_result = div_q[0];
    end else begin
      divresp_val = 1'b0;
      divresp_msg_result = 64'd0;
    end
    #1;
    exp_cmd_rdy = !m_req_pend && (exp_q.size() < 4);
    chk("cmd_rdy", 64'(cmd_rdy), 64'(exp_cmd_rdy));
    chk("divreq_val", 64'(divreq_val), 64'(m_req_pend));
    if (m_req_pend) begin
      chk("divreq_fn", 64'(divreq_msg_fn), 64'(m_req_fn));
      chk("divreq_a", 64'(divreq_msg_a), 64'(m_req_a));
      chk("divreq_b", 64'(divreq_msg_b), 64'(m_req_b));
    end
    chk("divresp_rdy", 64'(divresp_rdy), 64'(!m_rsp_val));
    chk("rsp_val", 64'(rsp_val), 64'(m_rsp_val));
    if (m_rsp_val && exp_q.size() != 0) begin
      chk("rsp_quot", 64'(rsp_msg_quot), 64'(exp_q[0].q));
      chk("rsp_rem", 64'(rsp_msg_rem), 64'(exp_q[0].r));
      chk("rsp_tag", 64'(rsp_msg_tag), 64'(exp_q[0].tag));
      chk("rsp_divzero", 64'(rsp_msg_divzero), 64'(exp_q[0].dz));
    end
    chk("outstanding", 64'(outstanding), 64'(exp_q.size()));
    chk("proto_err", 64'(proto_err), 64'(m_perr));

    if (divreq_val && divreq_rdy) n_qfire++;
    cf  = cmd_val && exp_cmd_rdy;
    rf  = m_rsp_val && rsp_rdy;
    qf  = m_req_pend && divreq_rdy;
    sf  = divresp_val && !m_rsp_val;
    unm = (exp_q.size() == (m_rsp_val ? 1 : 0));

    if (divresp_val && unm) m_perr = 1'b1;
    if (sf) begin
      if (!inject && div_q.size() != 0) void'(div_q.pop_front());
      if (!unm) m_rsp_val = 1'b1;
    end
    if (rf) begin
      o.tag = rsp_msg_tag; o.dz = rsp_msg_divzero; o.q = rsp_msg_quot; o.r = rsp_msg_rem;
      ret_log.push_back(o);
      void'(exp_q.pop_front());
      m_rsp_val = 1'b0;
    end
    if (qf) begin
      div_q.push_back(divide(m_req_fn, m_req_a, m_req_b));
      m_req_pend = 1'b0;
    end
    if (cf) begin
      m_req_pend = 1'b1;
      m_req_fn = cmd_msg_fn; m_req_a = cmd_msg_a; m_req_b = cmd_msg_b;
      res = divide(cmd_msg_fn, cmd_msg_a, cmd_msg_b);
      e.tag = cmd_msg_tag; e.dz = (cmd_msg_b == 32'd0); e.q = res[31:0]; e.r = res[63:32];
      exp_q.push_back(e);
    end
    last_cf = cf;
    @(negedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic fn, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    cmd_msg_fn = fn; cmd_msg_a = a; cmd_msg_b = b; cmd_msg_tag = tag;
  endtask

  task automatic send(input logic fn, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    int n;
    set_cmd(fn, a, b, tag);
    cmd_val = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_cf && n < 60);
    cmd_val = 1'b0;
    chk("send_timeout", 64'(last_cf), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_last(input string nm, input logic [31:0] q, input logic [31:0] r,
                          input logic [3:0] tag, input logic dz);
    rsp_t o;
    if (ret_log.size() == 0) begin
      chk({nm, "_missing"}, 64'd0, 64'd1);
    end else begin
      o = ret_log[$];
      chk({nm, "_quot"}, 64'(o.q), 64'(q));
      chk({nm, "_rem"}, 64'(o.r), 64'(r));
      chk({nm, "_tag"}, 64'(o.tag), 64'(tag));
      chk({nm, "_divzero"}, 64'(o.dz), 64'(dz));
    end
  endtask

  initial begin
    int base, nq0;
    logic [3:0] exp_tags [5];
    reset = 1'b0;
    cmd_val = 1'b0; set_cmd(1'b0, 32'd0, 32'd0, 4'd0);
    divreq_rdy = 1'b1; rsp_rdy = 1'b1;
    divresp_val = 1'b0; divresp_msg_result = 64'd0;
    #1;
    chk("rst_divreq_val", 64'(divreq_val), 64'd0);
    chk("rst_rsp_val", 64'(rsp_val), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    chk("rst_cmd_rdy", 64'(cmd_rdy), 64'd0);
    chk("rst_divreq_a", 64'(divreq_msg_a), 64'd0);
    chk("rst_rsp_quot", 64'(rsp_msg_quot), 64'd0);
    @(negedge clk); #1;
    reset = 1'b1;

    // 1: basic signed divide
    send(1'b1, 32'd20, 32'd3, 4'd5);
    drain();
    chk_last("t1", 32'd6, 32'd2, 4'd5, 1'b0);
    chk("t1_outstanding", 64'(outstanding), 64'd0);

    // 2: signed negative, unsigned large
    send(1'b1, 32'hFFFF_FFF9, 32'd2, 4'd1);
    drain();
    chk_last("t2a", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'd1, 1'b0);
    send(1'b0, 32'hFFFF_FFFF, 32'd16, 4'd2);
    drain();
    chk_last("t2b", 32'h0FFF_FFFF, 32'h0000_000F, 4'd2, 1'b0);

    // 3: fill to MAX_OUT, then drain while a 5th command waits
    base = ret_log.size();
    rsp_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) send(1'b0, 32'(100 + i), 32'(i), 4'(i));
    for (int i = 0; i < 4; i++) tick();
    chk("t3_full_cmd_rdy", 64'(cmd_rdy), 64'd0);
    chk("t3_full_outstanding", 64'(outstanding), 64'd4);
    rsp_rdy = 1'b1;
    send(1'b1, 32'd77, 32'd7, 4'd9);
    chk("t3_refill_outstanding", 64'(outstanding), 64'd4);
    drain();
    exp_tags[0] = 4'd1; exp_tags[1] = 4'd2; exp_tags[2] = 4'd3;
    exp_tags[3] = 4'd4; exp_tags[4] = 4'd9;
    chk("t3_count", 64'(ret_log.size() - base), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (base + i < ret_log.size())
        chk("t3_order", 64'(ret_log[base + i].tag), 64'(exp_tags[i]));
    end

    // 4: divider back-pressure
    divreq_rdy = 1'b0;
    send(1'b0, 32'd1000, 32'd7, 4'd3);
    set_cmd(1'b1, 32'd5, 32'd5, 4'd4);
    cmd_val = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("t4_hold_val", 64'(divreq_val), 64'd1);
    chk("t4_hold_a", 64'(divreq_msg_a), 64'd1000);
    chk("t4_hold_cmd_rdy", 64'(cmd_rdy), 64'd0);
    cmd_val = 1'b0;
    divreq_rdy = 1'b1;
    nq0 = n_qfire;
    for (int i = 0; i < 5; i++) tick();
    chk("t4_one_fire", 64'(n_qfire - nq0), 64'd1);
    drain();
    chk_last("t4", 32'd142, 32'd6, 4'd3, 1'b0);

    // 5: divide by zero, then stray divider response
    send(1'b0, 32'd9, 32'd0, 4'd7);
    drain();
    chk_last("t5", 32'hFFFF_FFFF, 32'd9, 4'd7, 1'b1);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_proto_err", 64'(proto_err), 64'd1);
    chk("t5_rsp_val", 64'(rsp_val), 64'd0);

    // 6: async reset mid-calculation
    stub_en = 1'b0;
    send(1'b1, 32'd50, 32'd5, 4'd11);
    for (int i = 0; i < 3; i++) tick();
    #2;
    reset = 1'b0;
    #1;
    chk("t6_divreq_val", 64'(divreq_val), 64'd0);
    chk("t6_rsp_val", 64'(rsp_val), 64'd0);
    chk("t6_outstanding", 64'(outstanding), 64'd0);
    chk("t6_proto_err", 64'(proto_err), 64'd0);
    chk("t6_cmd_rdy", 64'(cmd_rdy), 64'd0);
    exp_q.delete(); div_q.delete();
    m_req_pend = 1'b0; m_rsp_val = 1'b0; m_perr = 1'b0;
    @(negedge clk); #1;
    chk("t6_hold_outstanding", 64'(outstanding), 64'd0);
    reset = 1'b1;
    stub_en = 1'b1;
    send(1'b1, 32'd50, 32'd5, 4'd11);
    drain();
    chk_last("t6", 32'd10, 32'd0, 4'd11, 1'b0);
    chk("t6_proto_err_after", 64'(proto_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
